// File: rtl/tta_iline_server_pkg.sv
// tta_iline_server_pkg: shared fetch-line constants, state encoding and line-index helper.
package tta_iline_server_pkg;
    localparam int ADDR_WIDTH = 16;
    localparam int DATA_WIDTH = 32;
    localparam int WORD_BITS = 4;
    localparam int LINE_BITS = 5;
    localparam int WORDS_PER_LINE = 1 << WORD_BITS;
    typedef enum logic {ST_IDLE, ST_STREAM} state_t;
    function automatic logic [LINE_BITS-1:0] line_idx(input logic [ADDR_WIDTH-1:0] a);
        return a[LINE_BITS+WORD_BITS-1:WORD_BITS];
    endfunction
endpackage

// File: rtl/tta_iline_server_if.sv
// tta_iline_server_if: instruction-fetch handshake plus RAM preload port.
interface tta_iline_server_if
    import tta_iline_server_pkg::*;
#(
    parameter int AW = ADDR_WIDTH,
    parameter int DW = DATA_WIDTH,
    parameter int WB = WORD_BITS,
    parameter int LB = LINE_BITS
) ();
    logic fetch_i;
    logic abort_i;
    logic [AW-1:0] addr_i;
    logic ready_o;
    logic last_o;
    logic [DW-1:0] data_o;
    logic wr_i;
    logic [LB+WB-1:0] wr_addr_i;
    logic [DW-1:0] wr_data_i;
    modport server (input fetch_i, abort_i, addr_i, wr_i, wr_addr_i, wr_data_i,
                    output ready_o, last_o, data_o);
    modport client (output fetch_i, abort_i, addr_i, wr_i, wr_addr_i, wr_data_i,
                    input ready_o, last_o, data_o);
endinterface

// File: rtl/tta_iline_ram.sv
// tta_iline_ram: simple dual-port synchronous RAM, read-first, no reset.
module tta_iline_ram #(
    parameter int AW = 9,
    parameter int DW = 32
) (
    input  logic clk,
    input  logic wr,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);
    logic [DW-1:0] mem [1<<AW];
    always_ff @(posedge clk) begin
        if (wr) mem[wr_addr] <= wr_data;
        rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/tta_iline_server.sv
// tta_iline_server: streams a 16-word line from instruction RAM per fetch request.
module tta_iline_server
    import tta_iline_server_pkg::*;
(
    input logic clock_i,
    input logic reset_i,
    tta_iline_server_if.server bus
);
    localparam int AB = LINE_BITS + WORD_BITS;
    state_t state, state_n;
    logic [WORD_BITS-1:0] cnt, cnt_n;
    logic [LINE_BITS-1:0] line_q, line_n, fl;
    logic rdy, rdy_n, last;
    logic [AB-1:0] rd_addr;
    assign fl = line_idx(bus.addr_i);
    assign last = rdy && (&cnt);
    assign bus.ready_o = rdy;
    assign bus.last_o = last;
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        line_n = line_q;
        rdy_n = rdy;
        rd_addr = {line_q, cnt + 1'b1};
        if (bus.abort_i) begin
            // a fetch alongside abort restarts via one bubble cycle that re-reads word 0
            cnt_n = '0;
            rdy_n = 1'b0;
            state_n = bus.fetch_i ? ST_STREAM : ST_IDLE;
            line_n = bus.fetch_i ? fl : line_q;
            rd_addr = {fl, {WORD_BITS{1'b0}}};
        end else if (state == ST_IDLE || (last && bus.fetch_i)) begin
            rd_addr = {fl, {WORD_BITS{1'b0}}};
            if (bus.fetch_i) begin
                state_n = ST_STREAM;
                line_n = fl;
                cnt_n = '0;
                rdy_n = 1'b1;
            end
        end else if (!rdy) begin
            rd_addr = {line_q, cnt};
            rdy_n = 1'b1;
        end else if (last) begin
            state_n = ST_IDLE;
            rdy_n = 1'b0;
            cnt_n = '0;
        end else begin
            cnt_n = cnt + 1'b1;
        end
    end
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state <= ST_IDLE;
            cnt <= '0;
            line_q <= '0;
            rdy <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            line_q <= line_n;
            rdy <= rdy_n;
        end
    end
    tta_iline_ram #(.AW(AB), .DW(DATA_WIDTH)) u_ram (
        .clk(clock_i),
        .wr(bus.wr_i),
        .wr_addr(bus.wr_addr_i),
        .wr_data(bus.wr_data_i),
        .rd_addr(rd_addr),
        .rd_data(bus.data_o)
    );
endmodule
